// File: rtl/maxterm_pkg.sv
// Shared constants and state type for the maxterm extractor.
package maxterm_pkg;

    localparam int unsigned N_VARS = 4;
    localparam int unsigned TT_W   = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 5;

    // Highest truth-table index; the scan stops here instead of wrapping.
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/maxterm_last_detect.sv
// Flags the entry at i_idx as the final maxterm: it is zero and no zero bit lies above it.
module maxterm_last_detect
    import maxterm_pkg::*;
(
    input  logic [TT_W-1:0]  i_tt_q,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_last
);

    logic [TT_W-1:0] w_ge_mask;
    logic [TT_W-1:0] w_above_mask;

    // Mask of positions strictly above i_idx, then look for any zero there.
    always_comb begin
        w_ge_mask    = {TT_W{1'b1}} << i_idx;
        w_above_mask = {w_ge_mask[TT_W-2:0], 1'b0};
        o_last       = ~i_tt_q[i_idx] & ~(|(~i_tt_q & w_above_mask));
    end

endmodule

// File: rtl/maxterm_extractor.sv
// Scans a captured 4-input truth table and streams the indices of its zero entries.
module maxterm_extractor
    import maxterm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  tt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    state_e           w_state_d;
    logic [TT_W-1:0]  r_tt;
    logic [TT_W-1:0]  w_tt_d;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_d;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic             w_entry_zero;
    logic             w_last_zero;

    assign w_entry_zero = ~r_tt[r_idx];

    maxterm_last_detect u_last_detect (
        .i_tt_q (r_tt),
        .i_idx  (r_idx),
        .o_last (w_last_zero)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tt    <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_tt    <= w_tt_d;
            r_idx   <= w_idx_d;
            r_count <= w_count_d;
        end
    end

    // Next-state: one entry per cycle; a zero entry waits for the handshake.
    always_comb begin
        w_state_d = r_state;
        w_tt_d    = r_tt;
        w_idx_d   = r_idx;
        w_count_d = r_count;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_d = SCAN;
                    w_tt_d    = tt;
                    w_idx_d   = '0;
                    w_count_d = '0;
                end
            end
            SCAN: begin
                if (!w_entry_zero || out_ready) begin
                    if (w_entry_zero) begin
                        w_count_d = r_count + CNT_W'(1);
                    end
                    if (r_idx == IDX_MAX) begin
                        w_state_d = DONE;
                    end else begin
                        w_idx_d = r_idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, never on out_ready.
    always_comb begin
        out_valid = (r_state == SCAN) && w_entry_zero;
        out_last  = out_valid && w_last_zero;
        out_index = r_idx;
        count     = r_count;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
    end

endmodule

// File: tb/tb_maxterm_extractor.sv
// Self-checking bench for maxterm_extractor: directed table plus random truth tables.
module tb_maxterm_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] tt;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_index;
    logic        out_last;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxterm_extractor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tt        (tt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_last  (out_last),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [15:0] tt;
        int          mode;       // 0: always ready, 1: random ready, 2: ready low for 3 cycles
        bit          noise;      // pulse start with another tt mid-scan
        int          exp_count;
        int          exp_last;   // 16 when no maxterm is expected
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: the maxterms of t, in ascending order, consumed as the DUT hands them off.
    task automatic run_scan(input logic [15:0] t, input int mode, input bit noise,
                            output int got_count, output int got_last, output int got_done_cyc);
        int         q[$];
        int         n_exp;
        int         stall_left;
        bit         stalled;
        bit         finished;
        bit         rdy;
        logic [3:0] stall_idx;
        for (int i = 0; i < 16; i++) if (!t[i]) q.push_back(i);
        n_exp        = q.size();
        got_count    = -1;
        got_last     = 16;
        got_done_cyc = -1;
        stalled      = 1'b0;
        stall_idx    = '0;
        finished     = 1'b0;
        stall_left   = (mode == 2) ? 3 : 0;
        @(negedge clk);
        start     = 1'b1;
        tt        = t;
        out_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            tt    = 16'($urandom);
            if (noise && (c == 3 || c == 9)) begin
                start = 1'b1;
                tt    = ~t;
            end
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_index", out_index, stall_idx);
            end
            if (done) begin
                chk("done_busy", busy, 1);
                chk("done_count", count, n_exp);
                chk("done_remaining", q.size(), 0);
                got_count    = count;
                got_done_cyc = c;
                finished     = 1'b1;
                out_ready    = 1'b1;
            end else begin
                chk("scan_busy", busy, 1);
                if (out_valid) begin
                    chk("index", out_index, (q.size() > 0) ? q[0] : 16);
                    chk("last", out_last, q.size() == 1);
                    if (mode == 0) rdy = 1'b1;
                    else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                    else if (stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else rdy = 1'b1;
                    out_ready = rdy;
                    if (rdy && q.size() > 0) begin
                        if (out_last) got_last = out_index;
                        void'(q.pop_front());
                    end
                    stalled   = !rdy;
                    stall_idx = out_index;
                end else begin
                    chk("last_without_valid", out_last, 0);
                    out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
                    stalled   = 1'b0;
                end
            end
        end
        chk("done_timeout", finished, 1);
        if (finished) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_count_hold", count, n_exp);
        end
    endtask

    initial begin
        int gc, gl, gd, ne;
        logic [15:0] rt;

        rst       = 1'b1;
        start     = 1'b0;
        tt        = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        tbl[0] = '{16'hFFFF, 0, 1'b0, 0, 16};
        tbl[1] = '{16'h0000, 0, 1'b0, 16, 15};
        tbl[2] = '{16'h9898, 0, 1'b0, 10, 14};
        tbl[3] = '{16'hFFFE, 2, 1'b0, 1, 0};
        tbl[4] = '{16'h7FFF, 0, 1'b0, 1, 15};
        tbl[5] = '{16'h0001, 1, 1'b0, 15, 15};
        tbl[6] = '{16'h9898, 1, 1'b1, 10, 14};

        for (int v = 0; v < 7; v++) begin
            run_scan(tbl[v].tt, tbl[v].mode, tbl[v].noise, gc, gl, gd);
            chk($sformatf("tbl%0d_count", v), gc, tbl[v].exp_count);
            chk($sformatf("tbl%0d_last_index", v), gl, tbl[v].exp_last);
            if (tbl[v].mode == 0) chk($sformatf("tbl%0d_latency", v), gd, 17);
        end

        // Reset mid-scan after two handshakes: no done pulse, no resumption.
        @(negedge clk);
        start     = 1'b1;
        tt        = 16'h0000;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_index", out_index, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_no_resume", busy, 0);
        end

        // Random truth tables with random back-pressure.
        for (int r = 0; r < 25; r++) begin
            rt = 16'($urandom);
            ne = 0;
            for (int i = 0; i < 16; i++) if (!rt[i]) ne++;
            run_scan(rt, (r % 3 == 0) ? 0 : 1, 1'($urandom), gc, gl, gd);
            chk("rand_count", gc, ne);
            if (r % 3 == 0) chk("rand_latency", gd, 17);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
